// File: rtl/pe_accumulator_if.sv
// Product-beat input and result-FIFO output bundle of the PE accumulator.
// The producer/consumer side uses master; the accumulator uses slave.
interface pe_accumulator_if #(
    parameter int PROD_W = 64,
    parameter int OUT_W  = 32
);
    logic              in_valid;
    logic              in_first;
    logic              in_last;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_sat;
    logic              busy;
    logic              err_overrun;
    logic              err_proto;

    modport master (
        output in_valid, in_first, in_last, in_prod, out_ready,
        input  out_valid, out_data, out_sat, busy, err_overrun, err_proto
    );

    modport slave (
        input  in_valid, in_first, in_last, in_prod, out_ready,
        output out_valid, out_data, out_sat, busy, err_overrun, err_proto
    );
endinterface

// File: rtl/pe_accumulator.sv
// Signed dot-product accumulator with round/shift/saturate requantization
// and a 2-entry output FIFO; the input side never stalls.
module pe_accumulator #(
    parameter int PROD_W = 64,
    parameter int ACC_W  = 80,
    parameter int OUT_W  = 32,
    parameter int SHIFT  = 8
) (
    input logic              clk,
    input logic              rst_n,
    pe_accumulator_if.slave  bus
);
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACCUM = 1'b1} state_e;

    state_e            state_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  sum_q;
    logic              sum_v_q;
    logic              err_proto_q;
    logic [ACC_W-1:0]  prod_ext_s;
    logic [ACC_W-1:0]  acc_next_s;

    logic [OUT_W-1:0]  e0_data_q, e0_data_d, e1_data_q, e1_data_d;
    logic              e0_sat_q, e0_sat_d, e1_sat_q, e1_sat_d;
    logic              v0_q, v0_d, v1_q, v1_d;
    logic              err_overrun_q, err_overrun_d;

    logic signed [ACC_W:0] sum_ext_s;
    logic signed [ACC_W:0] r_s;
    logic [OUT_W:0]        res_s;
    logic                  push_s;
    logic                  pop_s;

    assign prod_ext_s = {{(ACC_W-PROD_W){bus.in_prod[PROD_W-1]}}, bus.in_prod};

    // Sum including the current beat; a first beat or a beat in IDLE restarts it.
    always_comb begin
        acc_next_s = prod_ext_s;
        if ((state_q == ST_ACCUM) && !bus.in_first) begin
            acc_next_s = acc_q + prod_ext_s;
        end else begin
            acc_next_s = prod_ext_s;
        end
    end

    // Dot-product FSM, accumulator and final-sum pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= {ACC_W{1'b0}};
            sum_q       <= {ACC_W{1'b0}};
            sum_v_q     <= 1'b0;
            err_proto_q <= 1'b0;
        end else begin
            sum_v_q <= 1'b0;
            if (bus.in_valid) begin
                acc_q <= acc_next_s;
                if (bus.in_last) begin
                    sum_q   <= acc_next_s;
                    sum_v_q <= 1'b1;
                end
                case (state_q)
                    ST_IDLE: begin
                        state_q <= bus.in_last ? ST_IDLE : ST_ACCUM;
                    end
                    ST_ACCUM: begin
                        if (bus.in_first) begin
                            err_proto_q <= 1'b1;
                        end
                        state_q <= bus.in_last ? ST_IDLE : ST_ACCUM;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // One extra bit keeps the rounding add from overflowing.
    assign sum_ext_s = {sum_q[ACC_W-1], sum_q};

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT-1);
            logic signed [ACC_W:0] rnd_s;
            assign rnd_s = sum_ext_s + $signed(HALF);
            assign r_s   = rnd_s >>> SHIFT;
        end else begin : g_noround
            assign r_s = sum_ext_s;
        end
    endgenerate

    // Clip to the signed output range; returns {sat, data}.
    function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W:0] r);
        logic [ACC_W-OUT_W+1:0] upper;
        logic [OUT_W:0]         res;
        upper = r[ACC_W:OUT_W-1];
        if ((&upper) || (~|upper)) begin
            res = {1'b0, r[OUT_W-1:0]};
        end else if (r[ACC_W]) begin
            res = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            res = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
        end
        return res;
    endfunction

    assign res_s  = saturate(r_s);
    assign push_s = sum_v_q;
    assign pop_s  = v0_q & bus.out_ready;

    // FIFO next state: entry 0 is the head, entry 1 the tail.
    always_comb begin
        e0_data_d     = e0_data_q;
        e0_sat_d      = e0_sat_q;
        e1_data_d     = e1_data_q;
        e1_sat_d      = e1_sat_q;
        v0_d          = v0_q;
        v1_d          = v1_q;
        err_overrun_d = err_overrun_q;
        case ({push_s, pop_s})
            2'b11: begin
                if (v1_q) begin
                    e0_data_d = e1_data_q;
                    e0_sat_d  = e1_sat_q;
                    e1_data_d = res_s[OUT_W-1:0];
                    e1_sat_d  = res_s[OUT_W];
                end else begin
                    e0_data_d = res_s[OUT_W-1:0];
                    e0_sat_d  = res_s[OUT_W];
                end
            end
            2'b01: begin
                e0_data_d = e1_data_q;
                e0_sat_d  = e1_sat_q;
                v0_d      = v1_q;
                v1_d      = 1'b0;
            end
            2'b10: begin
                if (!v0_q) begin
                    e0_data_d = res_s[OUT_W-1:0];
                    e0_sat_d  = res_s[OUT_W];
                    v0_d      = 1'b1;
                end else if (!v1_q) begin
                    e1_data_d = res_s[OUT_W-1:0];
                    e1_sat_d  = res_s[OUT_W];
                    v1_d      = 1'b1;
                end else begin
                    err_overrun_d = 1'b1;
                end
            end
            default: begin
                v0_d = v0_q;
            end
        endcase
    end

    // FIFO storage and sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_data_q     <= {OUT_W{1'b0}};
            e0_sat_q      <= 1'b0;
            e1_data_q     <= {OUT_W{1'b0}};
            e1_sat_q      <= 1'b0;
            v0_q          <= 1'b0;
            v1_q          <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            e0_data_q     <= e0_data_d;
            e0_sat_q      <= e0_sat_d;
            e1_data_q     <= e1_data_d;
            e1_sat_q      <= e1_sat_d;
            v0_q          <= v0_d;
            v1_q          <= v1_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign bus.out_valid   = v0_q;
    assign bus.out_data    = e0_data_q;
    assign bus.out_sat     = e0_sat_q;
    assign bus.busy        = (state_q == ST_ACCUM);
    assign bus.err_overrun = err_overrun_q;
    assign bus.err_proto   = err_proto_q;
endmodule

// File: tb/tb_pe_accumulator.sv
// Bench for pe_accumulator: constant vectors, directed corner sequences and
// random traffic compared against a queue-based reference model.
module tb_pe_accumulator;
    typedef logic signed [127:0] wide_t;

    typedef struct {
        logic signed [63:0] prod;
        logic [31:0]        exp_data;
        logic               exp_sat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    pe_accumulator_if #(.PROD_W(64), .OUT_W(32)) bus ();

    pe_accumulator #(.PROD_W(64), .ACC_W(80), .OUT_W(32), .SHIFT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic               m_open;
    logic signed [79:0] m_sum;
    logic               m_pend_v;
    logic [32:0]        m_pend;
    logic [32:0]        m_q[$];
    logic               m_ovr;
    logic               m_proto;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Floor division by 256 after adding one half, then clip to 32-bit signed.
    function automatic logic [32:0] ref_requant(input logic signed [79:0] s);
        wide_t v, q, maxv, minv;
        v = s;
        v = v + 128;
        q = v / 256;
        if (((v % 256) != 0) && (v < 0)) q = q - 1;
        maxv = (wide_t'(1) <<< 31) - 1;
        minv = -(wide_t'(1) <<< 31);
        if (q > maxv) return {1'b1, 32'h7FFF_FFFF};
        if (q < minv) return {1'b1, 32'h8000_0000};
        return {1'b0, q[31:0]};
    endfunction

    task automatic model_clear();
        m_open = 1'b0; m_sum = '0; m_pend_v = 1'b0; m_pend = '0;
        m_q.delete(); m_ovr = 1'b0; m_proto = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic f, input logic l,
                              input logic signed [63:0] p, input logic rdy);
        logic signed [79:0] pe;
        if ((m_q.size() > 0) && rdy) void'(m_q.pop_front());
        if (m_pend_v) begin
            if (m_q.size() < 2) m_q.push_back(m_pend);
            else m_ovr = 1'b1;
        end
        m_pend_v = 1'b0;
        if (v) begin
            pe = p;
            if (m_open && f) m_proto = 1'b1;
            if (!m_open || f) m_sum = pe;
            else m_sum = m_sum + pe;
            if (l) begin
                m_pend   = ref_requant(m_sum);
                m_pend_v = 1'b1;
                m_open   = 1'b0;
            end else begin
                m_open = 1'b1;
            end
        end
    endtask

    task automatic model_compare();
        chk("out_valid", bus.out_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            chk("out_data", bus.out_data, m_q[0][31:0]);
            chk("out_sat", bus.out_sat, m_q[0][32]);
        end
        chk("busy", bus.busy, m_open);
        chk("err_overrun", bus.err_overrun, m_ovr);
        chk("err_proto", bus.err_proto, m_proto);
    endtask

    task automatic step(input logic v, input logic f, input logic l,
                        input logic signed [63:0] p, input logic rdy);
        bus.in_valid  = v;
        bus.in_first  = f;
        bus.in_last   = l;
        bus.in_prod   = p;
        bus.out_ready = rdy;
        @(posedge clk);
        model_edge(v, f, l, p, rdy);
        #1;
        model_compare();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 1'b0, 64'sd0, rdy);
    endtask

    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        model_clear();
        for (int i = 0; i < cycles; i++) begin
            bus.in_valid  = 1'($urandom);
            bus.in_first  = 1'($urandom);
            bus.in_last   = 1'($urandom);
            bus.in_prod   = {$urandom, $urandom};
            bus.out_ready = 1'($urandom);
            @(posedge clk);
            #1;
            chk("rst out_valid", bus.out_valid, 1'b0);
            chk("rst out_data", bus.out_data, 32'h0);
            chk("rst out_sat", bus.out_sat, 1'b0);
            chk("rst busy", bus.busy, 1'b0);
            chk("rst err_overrun", bus.err_overrun, 1'b0);
            chk("rst err_proto", bus.err_proto, 1'b0);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        idle(1'b1);
        idle(1'b1);
    endtask

    vec_t vecs[10];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clk      = 1'b0;
        rst_n    = 1'b0;
        bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
        bus.in_prod  = '0;   bus.out_ready = 1'b0;

        vecs[0] = '{-64'sd384, 32'hFFFF_FFFF, 1'b0};
        vecs[1] = '{64'sh0000_0100_0000_0000, 32'h7FFF_FFFF, 1'b1};
        vecs[2] = '{64'shFFFF_FF00_0000_0000, 32'h8000_0000, 1'b1};
        vecs[3] = '{64'sd640, 32'd3, 1'b0};
        vecs[4] = '{64'sd128, 32'd1, 1'b0};
        vecs[5] = '{-64'sd128, 32'd0, 1'b0};
        vecs[6] = '{-64'sd129, 32'hFFFF_FFFF, 1'b0};
        vecs[7] = '{64'sh0000_007F_FFFF_FF00, 32'h7FFF_FFFF, 1'b0};
        vecs[8] = '{64'sh0000_007F_FFFF_FF80, 32'h7FFF_FFFF, 1'b1};
        vecs[9] = '{64'shFFFF_FF80_0000_0000, 32'h8000_0000, 1'b0};

        apply_reset(4);

        // Three-term dot product: 640/256 = 2.5 rounds to 3
        step(1'b1, 1'b1, 1'b0, 64'sd256, 1'b1);
        chk("A busy1", bus.busy, 1'b1);
        step(1'b1, 1'b0, 1'b0, 64'sd512, 1'b1);
        chk("A busy2", bus.busy, 1'b1);
        step(1'b1, 1'b0, 1'b1, -64'sd128, 1'b1);
        chk("A busy3", bus.busy, 1'b0);
        chk("A early", bus.out_valid, 1'b0);
        idle(1'b1);
        chk("A valid", bus.out_valid, 1'b1);
        chk("A data", bus.out_data, 32'd3);
        chk("A sat", bus.out_sat, 1'b0);
        idle(1'b1);
        chk("A pulse", bus.out_valid, 1'b0);

        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b1, vecs[i].prod, 1'b1);
            idle(1'b1);
            chk($sformatf("vec%0d valid", i), bus.out_valid, 1'b1);
            chk($sformatf("vec%0d data", i), bus.out_data, vecs[i].exp_data);
            chk($sformatf("vec%0d sat", i), bus.out_sat, vecs[i].exp_sat);
            idle(1'b1);
        end

        // Overrun: third result dropped while FIFO full and stalled
        apply_reset(2);
        step(1'b1, 1'b1, 1'b1, 64'sd256, 1'b0);
        step(1'b1, 1'b1, 1'b1, 64'sd512, 1'b0);
        step(1'b1, 1'b1, 1'b1, 64'sd768, 1'b0);
        idle(1'b0);
        chk("OVR flag", bus.err_overrun, 1'b1);
        chk("OVR head", bus.out_data, 32'd1);
        idle(1'b1);
        chk("OVR second", bus.out_data, 32'd2);
        chk("OVR second v", bus.out_valid, 1'b1);
        idle(1'b1);
        chk("OVR empty", bus.out_valid, 1'b0);

        // Full FIFO with simultaneous pop and push
        apply_reset(2);
        step(1'b1, 1'b1, 1'b1, 64'sd256, 1'b0);
        step(1'b1, 1'b1, 1'b1, 64'sd512, 1'b0);
        step(1'b1, 1'b1, 1'b1, 64'sd1024, 1'b0);
        idle(1'b1);
        chk("PP head", bus.out_data, 32'd2);
        chk("PP no ovr", bus.err_overrun, 1'b0);
        idle(1'b1);
        chk("PP tail", bus.out_data, 32'd4);
        idle(1'b1);
        chk("PP empty", bus.out_valid, 1'b0);

        // Protocol: restart while open, and open from IDLE without first
        apply_reset(2);
        step(1'b1, 1'b1, 1'b0, 64'sd256, 1'b1);
        step(1'b1, 1'b0, 1'b0, 64'sd256, 1'b1);
        step(1'b1, 1'b1, 1'b1, 64'sd512, 1'b1);
        chk("PR proto", bus.err_proto, 1'b1);
        idle(1'b1);
        chk("PR data", bus.out_data, 32'd2);
        step(1'b1, 1'b0, 1'b0, 64'sd256, 1'b1);
        chk("PR busy", bus.busy, 1'b1);
        step(1'b1, 1'b0, 1'b1, 64'sd256, 1'b1);
        idle(1'b1);
        chk("PR nofirst v", bus.out_valid, 1'b1);
        chk("PR nofirst", bus.out_data, 32'd2);
        idle(1'b1);

        // Reset in the middle of an open dot product
        step(1'b1, 1'b1, 1'b0, 64'sd256, 1'b1);
        step(1'b1, 1'b0, 1'b0, 64'sd256, 1'b1);
        apply_reset(2);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            chk("MR valid", bus.out_valid, 1'b0);
            chk("MR busy", bus.busy, 1'b0);
        end

        // Random traffic against the model
        apply_reset(2);
        for (int i = 0; i < 600; i++) begin
            logic signed [63:0] p;
            if (($urandom % 8) == 0) p = {$urandom, $urandom};
            else p = 64'($signed({1'b0, 31'($urandom_range(0, 8191))})) - 64'sd4096;
            step(($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 4) == 0,
                 p, ($urandom % 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
